sram_model_mw: RTL

Parametrised, cycle-based behavioural model of the external asynchronous SRAM.
- Adds over the fixed 16-bit, 64-word model:
  - configurable data width and depth
  - per-byte-lane write/read enables
  - chip- and output-enable gating
  - configurable read latency pipeline
  - optional out-of-range address checking
- Sits on the SRAM pins driven by the memory controller in simulation.
- Serves as the single memory back-end for all processor-level benches.

---
 rtl/sram_model_mw_pkg.sv | 28 ++
 rtl/sram_model_mw_if.sv | 25 ++
 rtl/sram_model_mw_rd_pipe.sv | 41 ++++
 rtl/sram_model_mw.sv | 101 ++++++++++
 4 files changed

// File: rtl/sram_model_mw_pkg.sv
// rtl/sram_model_mw_pkg.sv - shared constants and parameter helpers for the SRAM model
package sram_pkg;

  localparam int SRAM_MAX_READ_LAT = 4;

  function automatic int sram_lanes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int sram_clog2(input int value);
    int w;
    w = 0;
    while ((longint'(1) << w) < longint'(value)) w++;
    return w;
  endfunction

  function automatic bit sram_params_ok(input int data_w, input int addr_w,
                                        input int depth, input int read_lat);
    bit ok;
    ok = 1'b1;
    if (data_w < 8 || (data_w % 8) != 0) ok = 1'b0;
    if (depth < 2 || (depth & (depth - 1)) != 0) ok = 1'b0;
    if (addr_w < 1 || addr_w > 32 || longint'(depth) > (longint'(1) << addr_w)) ok = 1'b0;
    if (read_lat < 1 || read_lat > SRAM_MAX_READ_LAT) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sram_model_mw_if.sv
// rtl/sram_model_mw_if.sv - SRAM control pins plus model status flags (data bus stays a plain inout)
interface sram_model_mw_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
);
  import sram_pkg::*;

  logic [ADDR_W-1:0]             sram_addr;
  logic [sram_lanes(DATA_W)-1:0] sram_be_n;
  logic                          sram_we_n;
  logic                          sram_ce_n;
  logic                          sram_oe_n;
  logic                          rd_valid;
  logic                          addr_err;

  modport master (
    output sram_addr, sram_be_n, sram_we_n, sram_ce_n, sram_oe_n,
    input  rd_valid, addr_err
  );

  modport slave (
    input  sram_addr, sram_be_n, sram_we_n, sram_ce_n, sram_oe_n,
    output rd_valid, addr_err
  );
endinterface

// File: rtl/sram_model_mw_rd_pipe.sv
// rtl/sram_model_mw_rd_pipe.sv - READ_LAT-stage shift register of {valid, be_n, data}
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LANES    = sram_lanes(DATA_W),
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LANES-1:0]  in_be_n,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [LANES-1:0]  out_be_n,
  output logic [DATA_W-1:0] out_data
);

  typedef struct packed {
    logic              valid;
    logic [LANES-1:0]  be_n;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t stage_q [READ_LAT];

  // Shifts unconditionally: an entry that is not driven at the output is simply lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {in_valid, in_be_n, in_data};
      for (int i = 1; i < READ_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_valid = stage_q[READ_LAT-1].valid;
  assign out_be_n  = stage_q[READ_LAT-1].be_n;
  assign out_data  = stage_q[READ_LAT-1].data;

endmodule

// File: rtl/sram_model_mw.sv
// rtl/sram_model_mw.sv - cycle-based parametrised model of the external asynchronous SRAM
// Define SRAM_MODEL_ADDR_CHECK_EN to reject and flag accesses at or above DEPTH.
module sram_model_mw
  import sram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] sram_dq,
  sram_model_mw_if.slave    bus
);

  localparam int LANES = sram_lanes(DATA_W);
  localparam int IDX_W = sram_clog2(DEPTH);

  initial begin
    if (!sram_params_ok(DATA_W, ADDR_W, DEPTH, READ_LAT))
      $fatal(1, "sram_model_mw: illegal DATA_W/ADDR_W/DEPTH/READ_LAT %0d/%0d/%0d/%0d",
             DATA_W, ADDR_W, DEPTH, READ_LAT);
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              addr_ok;
  logic              wr_fire;
  logic              rd_fire;
  logic              out_valid;
  logic [LANES-1:0]  out_be_n;
  logic [DATA_W-1:0] out_data;
  logic              drive;
  logic [LANES-1:0]  lane_drive;

  assign idx = bus.sram_addr[IDX_W-1:0];

`ifdef SRAM_MODEL_ADDR_CHECK_EN
  logic addr_hi;
  logic addr_err_q;

  // DEPTH is a power of two, so any set bit above the index field is out of range.
  assign addr_hi = |(bus.sram_addr >> IDX_W);
  assign addr_ok = ~addr_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_q <= 1'b0;
    end else if (!bus.sram_ce_n && addr_hi) begin
      addr_err_q <= 1'b1;
      $display("%0t sram_model_mw: warning, address 0x%0h at or above depth %0d ignored",
               $time, bus.sram_addr, DEPTH);
    end
  end

  assign bus.addr_err = addr_err_q;
`else
  logic unused_addr;
  assign unused_addr  = ^bus.sram_addr;
  assign addr_ok      = 1'b1;
  assign bus.addr_err = 1'b0;
`endif

  assign wr_fire = ~bus.sram_ce_n & ~bus.sram_we_n & addr_ok;
  assign rd_fire = ~bus.sram_ce_n &  bus.sram_we_n & addr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < LANES; i++)
        if (!bus.sram_be_n[i]) mem[idx][8*i +: 8] <= sram_dq[8*i +: 8];
    end
  end

  sram_rd_pipe #(
    .DATA_W   (DATA_W),
    .LANES    (LANES),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_fire),
    .in_be_n   (bus.sram_be_n),
    .in_data   (mem[idx]),
    .out_valid (out_valid),
    .out_be_n  (out_be_n),
    .out_data  (out_data)
  );

  // Live enables gate the bus, so a falling we_n releases it in the same delta.
  assign drive        = out_valid & ~bus.sram_ce_n & ~bus.sram_oe_n & bus.sram_we_n;
  assign lane_drive   = {LANES{drive}} & ~out_be_n;
  assign bus.rd_valid = |lane_drive;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sram_dq[8*i +: 8] = lane_drive[i] ? out_data[8*i +: 8] : 8'bzzzz_zzzz;
  end

endmodule
